uart_rx_bit_sampler: RTL

Front-end of the UART receive path. Synchronises the asynchronous `rx` pin, detects the start-bit falling edge, times the centre of every bit with a per-bit clock divider, and emits exactly one single-cycle `baud_pulse` per bit together with the sampled line level. It sits directly upstream of the receive bit counter and shift logic, which count 11 pulses per frame: start, 8 data, parity, stop.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/uart_rx_bit_sampler.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, defaults and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA
    } state_t;

    localparam int FRAME_BITS_DEFAULT = 11;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser with a selectable reset level
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous input through two flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: start-edge detection and mid-bit sampling of the rx line
module uart_rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = clks_per_bit(50_000_000, 115_200),
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic baud_pulse,
    output logic rx_bit,
    output logic busy,
    output logic false_start,
    output logic frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] IDX_LAST = 4'(FRAME_BITS - 1);

    logic          rx_s;
    logic          rx_d;
    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_idx;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    // previous synchronised level for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_d <= 1'b1;
        else     rx_d <= rx_s;
    end

    // frame FSM: half-bit wait to the start centre, then full-bit steps; busy is cleared by IDLE so it drops one cycle after the stop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            baud_pulse  <= 1'b0;
            rx_bit      <= 1'b1;
            busy        <= 1'b0;
            false_start <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            baud_pulse  <= 1'b0;
            false_start <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                    busy     <= 1'b0;
                    if (rx_d && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            baud_pulse <= 1'b1;
                            rx_bit     <= 1'b0;
                            bit_idx    <= 4'd1;
                            state      <= DATA;
                        end else begin
                            false_start <= 1'b1;
                            state       <= IDLE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        baud_pulse <= 1'b1;
                        rx_bit     <= rx_s;
                        tick_cnt   <= '0;
                        if (bit_idx == IDX_LAST) begin
                            frame_err <= !rx_s;
                            state     <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
